// File: rtl/cfpu_mac.sv
// cfpu_mac: complex float multiply-accumulate; sums N products per frame, one result per frame.
// Complex = {re, im}, each IEEE binary32. Optional macro CFPU_MAC_LAST_EN enables in_last frame ends.
module cfpu_mac #(
  parameter  int N     = 8,
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_A,
  input  logic [63:0] in_B,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam logic [31:0] FP_NAN = 32'h7FC0_0000;

  // Round-to-nearest-even and pack; m carries the leading one in bit 23.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [23:0] m, input logic g, input logic st);
    logic [24:0]       r;
    logic signed [9:0] ee;
    r  = {1'b0, m} + {24'd0, g & (st | m[0])};
    ee = e;
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 10'sd1;
    end
    if (ee >= 10'sd255) return {s, 8'hFF, 23'd0};
    else if (ee <= 10'sd0) return {s, 31'd0};
    else return {s, ee[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
          a[30:23] == 8'd0 || b[30:23] == 8'd0) return FP_NAN;
      else return {s, 8'hFF, 23'd0};
    end else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      return {s, 31'd0};
    end else begin
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47]) e = e + 10'sd1;
      else p = p << 1;
      return fp_pack(s, e, p[47:24], p[23], |p[22:0]);
    end
  endfunction

  // Larger magnitude goes to x; subnormals are flushed to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my;
    logic              sticky;
    logic [27:0]       s;
    logic signed [9:0] e;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    if (x[30:23] == 8'hFF) begin
      return (y[30:23] == 8'hFF && x[31] != y[31]) ? FP_NAN : x;
    end else if (x[30:23] == 8'd0) begin
      return {x[31] & y[31], 31'd0};
    end else if (y[30:23] == 8'd0) begin
      return x;
    end else begin
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      if (d > 8'd26) begin
        my = 27'd1;
      end else begin
        sticky = (my & ((27'd1 << d) - 27'd1)) != 27'd0;
        my     = (my >> d) | {26'd0, sticky};
      end
      s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
      e = $signed({2'b00, x[30:23]});
      if (s == 28'd0) begin
        return 32'd0;
      end else if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end else begin
        for (int i = 0; i < 26; i++) begin
          if (!s[26]) begin
            s = s << 1;
            e = e - 10'sd1;
          end
        end
      end
      return fp_pack(x[31], e, s[26:3], s[2], s[1] | s[0]);
    end
  endfunction

  function automatic logic [63:0] c_mul(input logic [63:0] a, input logic [63:0] b);
    logic [31:0] t;
    t = fp_mul(a[31:0], b[31:0]);
    return {fp_add(fp_mul(a[63:32], b[63:32]), {~t[31], t[30:0]}),
            fp_add(fp_mul(a[63:32], b[31:0]), fp_mul(a[31:0], b[63:32]))};
  endfunction

  function automatic logic [63:0] c_add(input logic [63:0] a, input logic [63:0] b);
    return {fp_add(a[63:32], b[63:32]), fp_add(a[31:0], b[31:0])};
  endfunction

  logic [63:0]      r_p, r_acc, r_out_data;
  logic             r_p_valid, r_p_last, r_first, r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stall, w_xfer, w_term_last, w_out_load;
  logic [63:0]      w_prod, w_sum;

  // Handshake, frame-end detection and the product/accumulate datapath.
  always_comb begin
    w_stall    = r_p_valid & r_p_last & r_out_valid & ~out_ready;
    w_xfer     = in_valid & ~w_stall;
    w_out_load = r_p_valid & r_p_last & ~w_stall;
`ifdef CFPU_MAC_LAST_EN
    w_term_last = (r_cnt == CNT_W'(N - 1)) | in_last;
`else
    w_term_last = (r_cnt == CNT_W'(N - 1));
`endif
    w_prod = c_mul(in_A, in_B);
    w_sum  = r_first ? r_p : c_add(r_acc, r_p);
  end

`ifndef CFPU_MAC_LAST_EN
  logic w_unused;
  assign w_unused = in_last;
`endif

  assign in_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Stage 1: product register and term counter; a stalled last product is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p       <= 64'd0;
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
    end else if (w_xfer) begin
      r_p       <= w_prod;
      r_p_valid <= 1'b1;
      r_p_last  <= w_term_last;
      r_cnt     <= w_term_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
    end else if (!w_stall) begin
      r_p_valid <= 1'b0;
    end else begin
      r_p_valid <= r_p_valid;
    end
  end

  // Stage 2: accumulate; a last product writes the output and rearms the first-term flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= 64'd0;
      r_first     <= 1'b1;
      r_out_data  <= 64'd0;
      r_out_valid <= 1'b0;
    end else if (w_out_load) begin
      r_out_data  <= w_sum;
      r_out_valid <= 1'b1;
      r_first     <= 1'b1;
    end else begin
      if (r_p_valid && !r_p_last) begin
        r_acc   <= w_sum;
        r_first <= 1'b0;
      end
      if (out_ready) r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfpu_mac.sv
// Directed self-checking bench for cfpu_mac (N=8 and N=1 instances).
`timescale 1ns/1ps
module tb_cfpu_mac;

  localparam logic [31:0] F0   = 32'h0000_0000, F1  = 32'h3F80_0000, F2  = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000, F4  = 32'h4080_0000, F8  = 32'h4100_0000;
  localparam logic [31:0] F16  = 32'h4180_0000, F24 = 32'h41C0_0000, F36 = 32'h4210_0000;
  localparam logic [31:0] FH   = 32'h3F00_0000, FNH = 32'hBF00_0000, F15 = 32'h3FC0_0000;
  localparam logic [31:0] FN8  = 32'hC100_0000;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [63:0] in_A, in_B, out_data;
  logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready;
  logic [63:0] v1_in_A, v1_in_B, v1_out_data;
  vec_t        vecs [5];
  logic [31:0] fk [8];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  cfpu_mac #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  cfpu_mac #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_A(v1_in_A),
    .in_B(v1_in_B), .in_last(1'b0), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
    .out_data(v1_out_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n terms (in_last on term last_idx), then checks the two-cycle result latency.
  task automatic run_frame(input string name, input logic [63:0] a, input logic [63:0] b,
                           input int n, input int last_idx, input logic [63:0] exp);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_A     = a;
      in_B     = b;
      in_last  = (k == last_idx);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, "_lat1"}, {63'd0, out_valid}, 64'd0);
    tick();
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_data"}, out_data, exp);
    tick();
    check({name, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{{F1, F1},  {F1, F0},  {F8, F8}};
    vecs[1] = '{{F2, F0},  {F0, F1},  {F0, F16}};
    vecs[2] = '{{F0, F1},  {F0, F1},  {FN8, F0}};
    vecs[3] = '{{F15, F0}, {F2, F0},  {F24, F0}};
    vecs[4] = '{{FH, FH},  {FH, FNH}, {F4, F0}};
    fk = '{F1, F2, F3, F4, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, F8};

    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_A = 64'd0; in_B = 64'd0; out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_in_A = 64'd0; v1_in_B = 64'd0; v1_out_ready = 1'b1;
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", out_data, 64'd0);
    #20 rst = 1'b1;
    tick();
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    for (int r = 0; r < 5; r++)
      run_frame($sformatf("vec%0d", r), vecs[r].a, vecs[r].b, 8, -1, vecs[r].exp);

    // Back-to-back frames with the consumer stalled.
    out_ready = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check($sformatf("b2b_in_ready%0d", j), {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_A     = (j < 8) ? {F1, F0} : {fk[j-8], F0};
      in_B     = {F1, F0};
      tick();
    end
    in_valid = 1'b0;
    check("b2b_stall_ready", {63'd0, in_ready}, 64'd0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("b2b_hold_ready%0d", j), {63'd0, in_ready}, 64'd0);
      check($sformatf("b2b_hold_valid%0d", j), {63'd0, out_valid}, 64'd1);
      check($sformatf("b2b_hold_data%0d", j), out_data, {F8, F0});
    end
    out_ready = 1'b1;
    #1;
    check("b2b_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("b2b_second_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_second_data", out_data, {F36, F0});
    tick();
    check("b2b_drain", {63'd0, out_valid}, 64'd0);

`ifdef CFPU_MAC_LAST_EN
    run_frame("last_short", {F1, F0}, {F1, F0}, 3, 2, {F3, F0});
    run_frame("last_next", {F1, F0}, {F1, F0}, 8, -1, {F8, F0});
`else
    run_frame("last_ignored", {F1, F0}, {F1, F0}, 8, 2, {F8, F0});
`endif

    // Asynchronous reset mid-frame while a result is held.
    out_ready = 1'b0;
    for (int j = 0; j < 11; j++) begin
      in_valid = 1'b1;
      in_A     = {F1, F1};
      in_B     = {F1, F0};
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("prerst_valid", {63'd0, out_valid}, 64'd1);
    check("prerst_data", out_data, {F8, F8});
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_data", out_data, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd1);
    #3 rst = 1'b1;
    out_ready = 1'b1;
    tick();
    run_frame("postrst", {F2, F0}, {F1, F0}, 8, -1, {F16, F0});

    // N=1: every term is a frame, output stays valid each cycle.
    v1_in_valid = 1'b1;
    v1_in_A     = {F3, F0};
    v1_in_B     = {FH, F0};
    tick();
    check("n1_lat1", {63'd0, v1_out_valid}, 64'd0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("n1_valid%0d", j), {63'd0, v1_out_valid}, 64'd1);
      check($sformatf("n1_data%0d", j), v1_out_data, {F15, F0});
      check($sformatf("n1_ready%0d", j), {63'd0, v1_in_ready}, 64'd1);
    end
    v1_in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
